// File: rtl/bp_fe_pkg.sv
// Shared constants and assertion message codes for the FE dual-issue fetch queue.
package bp_fe_pkg;

  localparam int fe_queue_width_gp = 128;
  localparam int fe_lanes_gp       = 2;

  typedef enum logic [1:0] {
    e_msg_enq_not_ready,
    e_msg_deq_out_of_order,
    e_msg_deq_not_valid
  } bp_fe_assert_msg_e;

  // Number of asserted lanes, 0..2.
  function automatic logic [1:0] bp_fe_lane_sum(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

`ifndef SYNTHESIS
  function automatic string bp_fe_msg_text(input bp_fe_assert_msg_e msg);
    case (msg)
      e_msg_enq_not_ready:    return "enqueue while queue not ready, packets dropped";
      e_msg_deq_out_of_order: return "lane-2 dequeue without lane-1 dequeue";
      e_msg_deq_not_valid:    return "dequeue of an entry that is not valid";
      default:                return "unknown";
    endcase
  endfunction
`endif

endpackage

// File: rtl/bp_fe_dual_queue_mem.sv
// Queue storage: els_p entries, two write ports, two asynchronous read ports, async clear on reset.
module bp_fe_dual_queue_mem
  import bp_fe_pkg::*;
#(
  parameter  int els_p    = 8,
  parameter  int width_p  = fe_queue_width_gp,
  localparam int idx_w_lp = $clog2(els_p)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                w0_v,
  input  logic [idx_w_lp-1:0] w0_addr,
  input  logic [width_p-1:0]  w0_data,
  input  logic                w1_v,
  input  logic [idx_w_lp-1:0] w1_addr,
  input  logic [width_p-1:0]  w1_data,
  input  logic [idx_w_lp-1:0] r0_addr,
  output logic [width_p-1:0]  r0_data,
  input  logic [idx_w_lp-1:0] r1_addr,
  output logic [width_p-1:0]  r1_data
);

  logic [width_p-1:0] mem_r [els_p];

  // The two write addresses are always consecutive, so they never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
    end else begin
      if (w0_v) mem_r[w0_addr] <= w0_data;
      if (w1_v) mem_r[w1_addr] <= w1_data;
    end
  end

  assign r0_data = mem_r[r0_addr];
  assign r1_data = mem_r[r1_addr];

endmodule

// File: rtl/bp_fe_dual_queue.sv
// Dual-issue FE fetch queue: two enqueue lanes, oldest two entries presented to the BE, flush on clear_i.
// Define BP_FE_QUEUE_BYPASS_EN to forward packets into an empty / single-entry queue in the same cycle.
module bp_fe_dual_queue
  import bp_fe_pkg::*;
#(
  parameter  int els_p            = 8,
  parameter  int fe_queue_width_p = fe_queue_width_gp,
  localparam int ptr_width_lp     = $clog2(els_p) + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        clear_i,
  input  logic                        enq_v1_i,
  input  logic                        enq_v2_i,
  input  logic [fe_queue_width_p-1:0] enq1_i,
  input  logic [fe_queue_width_p-1:0] enq2_i,
  output logic                        enq_ready_o,
  output logic [fe_queue_width_p-1:0] fe_queue1_o,
  output logic [fe_queue_width_p-1:0] fe_queue2_o,
  output logic                        fe_queue_v1_o,
  output logic                        fe_queue_v2_o,
  input  logic                        deq_v1_i,
  input  logic                        deq_v2_i,
  output logic [ptr_width_lp-1:0]     count_o
);

  localparam int idx_w_lp = ptr_width_lp - 1;

  logic [ptr_width_lp-1:0]     rd_ptr_r, wr_ptr_r, count;
  logic [idx_w_lp-1:0]         rd_idx0, rd_idx1, wr_idx0, wr_idx1;
  logic [fe_queue_width_p-1:0] rd_data0, rd_data1;
  logic [fe_queue_width_p-1:0] lane0_data, lane1_data;
  logic                        mem_v1, mem_v2;
  logic                        enq_any, enq_fire, deq1_ok, deq2_ok;
  logic [1:0]                  n_enq, n_deq, n_skip, n_wr;

  assign count       = wr_ptr_r - rd_ptr_r;
  assign count_o     = count;
  assign enq_ready_o = (count <= ptr_width_lp'(els_p - 2));

  assign rd_idx0 = rd_ptr_r[idx_w_lp-1:0];
  assign rd_idx1 = rd_idx0 + idx_w_lp'(1);
  assign wr_idx0 = wr_ptr_r[idx_w_lp-1:0];
  assign wr_idx1 = wr_idx0 + idx_w_lp'(1);

  // Compacted enqueue lanes: lane 0 is the oldest valid packet.
  assign lane0_data = enq_v1_i ? enq1_i : enq2_i;
  assign lane1_data = enq2_i;
  assign enq_any    = enq_v1_i | enq_v2_i;
  assign enq_fire   = enq_any & enq_ready_o & ~clear_i;
  assign n_enq      = enq_fire ? bp_fe_lane_sum(enq_v1_i, enq_v2_i) : 2'd0;

  assign mem_v1 = (count != '0);
  assign mem_v2 = (count > ptr_width_lp'(1));

  always_comb begin
    fe_queue_v1_o = mem_v1;
    fe_queue_v2_o = mem_v2;
    fe_queue1_o   = rd_data0;
    fe_queue2_o   = rd_data1;
`ifdef BP_FE_QUEUE_BYPASS_EN
    if (!clear_i && enq_any && count == '0) begin
      fe_queue_v1_o = 1'b1;
      fe_queue_v2_o = enq_v1_i & enq_v2_i;
      fe_queue1_o   = lane0_data;
      fe_queue2_o   = lane1_data;
    end else if (!clear_i && enq_any && count == ptr_width_lp'(1)) begin
      fe_queue_v2_o = 1'b1;
      fe_queue2_o   = lane0_data;
    end
`endif
  end

  // Illegal dequeues are masked so a protocol slip cannot corrupt the pointers.
  assign deq1_ok = deq_v1_i & fe_queue_v1_o & ~clear_i;
  assign deq2_ok = deq_v2_i & deq1_ok & fe_queue_v2_o;
  assign n_deq   = bp_fe_lane_sum(deq1_ok, deq2_ok);

`ifdef BP_FE_QUEUE_BYPASS_EN
  // From an empty queue, dequeued packets come straight off the enqueue lanes and are never stored.
  assign n_skip = (count == '0) ? n_deq : 2'd0;
`else
  assign n_skip = 2'd0;
`endif
  assign n_wr = n_enq - n_skip;

  bp_fe_dual_queue_mem #(
    .els_p   (els_p),
    .width_p (fe_queue_width_p)
  ) mem (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .w0_v    (n_wr != 2'd0),
    .w0_addr (wr_idx0),
    .w0_data ((n_skip != 2'd0) ? lane1_data : lane0_data),
    .w1_v    (n_wr == 2'd2),
    .w1_addr (wr_idx1),
    .w1_data (lane1_data),
    .r0_addr (rd_idx0),
    .r0_data (rd_data0),
    .r1_addr (rd_idx1),
    .r1_data (rd_data1)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else if (clear_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_r + ptr_width_lp'(n_deq - n_skip);
      wr_ptr_r <= wr_ptr_r + ptr_width_lp'(n_wr);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i && !clear_i) begin
      assert (!(enq_any && !enq_ready_o))
        else $warning("bp_fe_dual_queue: %s", bp_fe_msg_text(e_msg_enq_not_ready));
      assert (!(deq_v2_i && !deq_v1_i))
        else $error("bp_fe_dual_queue: %s", bp_fe_msg_text(e_msg_deq_out_of_order));
      assert (!((deq_v1_i && !fe_queue_v1_o) || (deq_v2_i && !fe_queue_v2_o)))
        else $error("bp_fe_dual_queue: %s", bp_fe_msg_text(e_msg_deq_not_valid));
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_dual_queue.sv
// Self-checking bench for bp_fe_dual_queue (els_p = 8) against a packet-queue reference model.
module tb_bp_fe_dual_queue;

  localparam int els_lp = 8;
  localparam int w_lp   = 128;
  localparam int pw_lp  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clear, enq_v1, enq_v2, deq_v1, deq_v2;
  logic [w_lp-1:0]   enq1, enq2;
  logic              enq_ready, fe_v1, fe_v2;
  logic [w_lp-1:0]   fe_q1, fe_q2;
  logic [pw_lp-1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [w_lp-1:0] model_q[$];

  always #5 clk = ~clk;

  bp_fe_dual_queue #(.els_p(els_lp), .fe_queue_width_p(w_lp)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .clear_i       (clear),
    .enq_v1_i      (enq_v1),
    .enq_v2_i      (enq_v2),
    .enq1_i        (enq1),
    .enq2_i        (enq2),
    .enq_ready_o   (enq_ready),
    .fe_queue1_o   (fe_q1),
    .fe_queue2_o   (fe_q2),
    .fe_queue_v1_o (fe_v1),
    .fe_queue_v2_o (fe_v2),
    .deq_v1_i      (deq_v1),
    .deq_v2_i      (deq_v2),
    .count_o       (count)
  );

  function automatic logic [w_lp-1:0] rand_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle_inputs();
    clear = 0; enq_v1 = 0; enq_v2 = 0; deq_v1 = 0; deq_v2 = 0;
    enq1 = '0; enq2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    model_q.delete();
  endtask

  // One clock of stimulus; the model applies the queue rules: clear empties, a ready queue appends
  // the valid packets oldest-first, and each dequeue removes the oldest packet.
  task automatic drive_cycle(input logic clr, input logic v1, input logic v2,
                             input logic [w_lp-1:0] d1, input logic [w_lp-1:0] d2,
                             input logic dq1, input logic dq2);
    bit ready;
    @(negedge clk);
    clear = clr; enq_v1 = v1; enq_v2 = v2; enq1 = d1; enq2 = d2; deq_v1 = dq1; deq_v2 = dq2;
    ready = (els_lp - model_q.size()) >= 2;
    @(posedge clk);
    if (clr) model_q.delete();
    else begin
      if (ready && v1) model_q.push_back(d1);
      if (ready && v2) model_q.push_back(d2);
      if (dq1) void'(model_q.pop_front());
      if (dq2) void'(model_q.pop_front());
    end
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", enq_ready); end
    n_checks++; if ({fe_v1, fe_v2} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", {fe_v1, fe_v2}); end
    n_checks++; if (fe_q1 !== '0 || fe_q2 !== '0) begin n_fail++; $display("FAIL reset_data: got %0h/%0h expected 0/0", fe_q1, fe_q2); end
  endtask

  task automatic test_pair();
    logic [w_lp-1:0] a, b;
    do_reset();
    a = rand_pkt(); b = rand_pkt();
    drive_cycle(0, 1, 1, a, b, 0, 0);
    n_checks++; if ({fe_v1, fe_v2} !== 2'b11) begin n_fail++; $display("FAIL pair_valid: got %b expected 11", {fe_v1, fe_v2}); end
    n_checks++; if (fe_q1 !== a) begin n_fail++; $display("FAIL pair_q1: got %0h expected %0h", fe_q1, a); end
    n_checks++; if (fe_q2 !== b) begin n_fail++; $display("FAIL pair_q2: got %0h expected %0h", fe_q2, b); end
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL pair_count: got %0d expected 2", count); end
  endtask

  task automatic test_fill();
    logic [w_lp-1:0] first;
    do_reset();
    first = rand_pkt();
    drive_cycle(0, 1, 1, first, rand_pkt(), 0, 0);
    for (int i = 0; i < 2; i++) drive_cycle(0, 1, 1, rand_pkt(), rand_pkt(), 0, 0);
    n_checks++; if (count !== 4'd6) begin n_fail++; $display("FAIL fill6_count: got %0d expected 6", count); end
    n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL fill6_ready: got %0b expected 1", enq_ready); end
    drive_cycle(0, 1, 1, rand_pkt(), rand_pkt(), 0, 0);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill8_count: got %0d expected 8", count); end
    n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill8_ready: got %0b expected 0", enq_ready); end
    drive_cycle(0, 1, 1, rand_pkt(), rand_pkt(), 0, 0);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_drop_count: got %0d expected 8", count); end
    n_checks++; if (fe_q1 !== first) begin n_fail++; $display("FAIL full_drop_head: got %0h expected %0h", fe_q1, first); end
    drive_cycle(0, 0, 0, '0, '0, 1, 0);
    n_checks++; if (count !== 4'd7 || enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill7: got count %0d ready %0b expected 7/0", count, enq_ready); end
    drive_cycle(0, 0, 0, '0, '0, 1, 0);
    n_checks++; if (count !== 4'd6 || enq_ready !== 1'b1) begin n_fail++; $display("FAIL drain6: got count %0d ready %0b expected 6/1", count, enq_ready); end
  endtask

  task automatic test_wrap();
    logic [w_lp-1:0] x, c, p, q;
    bit dq1, dq2, v1, v2;
    do_reset();
    x = rand_pkt(); c = rand_pkt(); p = rand_pkt(); q = rand_pkt();
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 1, rand_pkt(), rand_pkt(), 0, 0);
    drive_cycle(0, 0, 0, '0, '0, 1, 1);
    drive_cycle(0, 0, 0, '0, '0, 1, 1);
    drive_cycle(0, 1, 0, x, '0, 0, 0);
    drive_cycle(0, 0, 1, '0, c, 0, 0);
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL wrap_v2only_count: got %0d expected 4", count); end
    drive_cycle(0, 0, 0, '0, '0, 1, 1);
    n_checks++; if (fe_q1 !== x) begin n_fail++; $display("FAIL wrap_order_q1: got %0h expected %0h", fe_q1, x); end
    n_checks++; if (fe_q2 !== c) begin n_fail++; $display("FAIL wrap_v2only_q2: got %0h expected %0h", fe_q2, c); end
    // Mixed traffic across the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      v1 = (model_q.size() <= 6) && $urandom_range(0, 1);
      v2 = (model_q.size() <= 6) && $urandom_range(0, 1);
      dq1 = (model_q.size() >= 1) && $urandom_range(0, 1);
      dq2 = dq1 && (model_q.size() >= 2) && $urandom_range(0, 1);
`ifdef BP_FE_QUEUE_BYPASS_EN
      dq1 = 0; dq2 = 0;
      if (model_q.size() >= 1) dq1 = $urandom_range(0, 1);
`endif
      drive_cycle(0, v1, v2, rand_pkt(), rand_pkt(), dq1, dq2);
      n_checks++; if (count !== pw_lp'(model_q.size())) begin n_fail++; $display("FAIL wrap_mix_count: got %0d expected %0d", count, model_q.size()); end
      if (model_q.size() >= 1) begin
        n_checks++; if (fe_q1 !== model_q[0]) begin n_fail++; $display("FAIL wrap_mix_q1: got %0h expected %0h", fe_q1, model_q[0]); end
      end
    end
    // Lane-2 write from index 7 rolls over to index 0.
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 1, rand_pkt(), rand_pkt(), 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, '0, '0, 1, 1);
    drive_cycle(0, 1, 0, x, '0, 0, 0);
    drive_cycle(0, 1, 1, p, q, 1, 0);
    n_checks++; if (fe_q1 !== p || fe_q2 !== q) begin n_fail++; $display("FAIL lane2_wrap: got %0h/%0h expected %0h/%0h", fe_q1, fe_q2, p, q); end
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL lane2_wrap_count: got %0d expected 2", count); end
  endtask

  task automatic test_deq_enq();
    logic [w_lp-1:0] d, e, f;
    do_reset();
    d = rand_pkt(); e = rand_pkt(); f = rand_pkt();
    drive_cycle(0, 1, 0, d, '0, 0, 0);
    drive_cycle(0, 1, 1, e, f, 1, 0);
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL deq_enq_count: got %0d expected 2", count); end
    n_checks++; if (fe_q1 !== e || fe_q2 !== f) begin n_fail++; $display("FAIL deq_enq_data: got %0h/%0h expected %0h/%0h", fe_q1, fe_q2, e, f); end
  endtask

  task automatic test_clear();
    logic [w_lp-1:0] k, l;
    do_reset();
    k = rand_pkt(); l = rand_pkt();
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 1, rand_pkt(), rand_pkt(), 0, 0);
    drive_cycle(0, 0, 0, '0, '0, 1, 0);
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL clear_pre_count: got %0d expected 5", count); end
    drive_cycle(1, 1, 1, rand_pkt(), rand_pkt(), 1, 0);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL clear_count: got %0d expected 0", count); end
    n_checks++; if ({fe_v1, fe_v2} !== 2'b00) begin n_fail++; $display("FAIL clear_valid: got %b expected 00", {fe_v1, fe_v2}); end
    n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready: got %0b expected 1", enq_ready); end
    drive_cycle(0, 1, 1, k, l, 0, 0);
    n_checks++; if (fe_q1 !== k || fe_q2 !== l || count !== 4'd2) begin n_fail++; $display("FAIL clear_refill: got %0h/%0h cnt %0d expected %0h/%0h cnt 2", fe_q1, fe_q2, count, k, l); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 2; i++) drive_cycle(0, 1, 1, rand_pkt(), rand_pkt(), 0, 0);
    #2;
    reset_n = 0;
    #1;
    n_checks++; if (count !== 4'd0 || fe_v1 !== 1'b0 || enq_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_state: got cnt %0d v1 %0b rdy %0b expected 0/0/1", count, fe_v1, enq_ready); end
    n_checks++; if (fe_q1 !== '0 || fe_q2 !== '0) begin n_fail++; $display("FAIL mid_reset_data: got %0h/%0h expected 0/0", fe_q1, fe_q2); end
    @(negedge clk);
    reset_n = 1;
    model_q.delete();
  endtask

  task automatic test_bypass();
    logic [w_lp-1:0] g;
    do_reset();
    g = rand_pkt();
    @(negedge clk);
    enq_v1 = 1; enq1 = g;
`ifdef BP_FE_QUEUE_BYPASS_EN
    deq_v1 = 1;
`endif
    #1;
`ifdef BP_FE_QUEUE_BYPASS_EN
    n_checks++; if (fe_v1 !== 1'b1 || fe_q1 !== g) begin n_fail++; $display("FAIL bypass_same_cycle: got v1 %0b %0h expected 1 %0h", fe_v1, fe_q1, g); end
`else
    n_checks++; if (fe_v1 !== 1'b0) begin n_fail++; $display("FAIL no_bypass_same_cycle: got v1 %0b expected 0", fe_v1); end
`endif
    @(posedge clk);
`ifndef BP_FE_QUEUE_BYPASS_EN
    model_q.push_back(g);
`endif
    #1;
    idle_inputs();
    n_checks++; if (count !== pw_lp'(model_q.size())) begin n_fail++; $display("FAIL bypass_next_count: got %0d expected %0d", count, model_q.size()); end
  endtask

  task automatic test_random();
    bit clr, v1, v2, dq1, dq2;
    int vis, n_enq;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 39) == 0);
      v1 = (model_q.size() <= 6) && ($urandom_range(0, 9) < ((i / 50) % 2 ? 3 : 8));
      v2 = (model_q.size() <= 6) && ($urandom_range(0, 9) < ((i / 50) % 2 ? 3 : 8));
      n_enq = (clr ? 0 : int'(v1) + int'(v2));
      vis = model_q.size();
`ifdef BP_FE_QUEUE_BYPASS_EN
      vis = vis + n_enq;
`endif
      if (vis > 2) vis = 2;
      dq1 = (vis >= 1) && $urandom_range(0, 1);
      dq2 = dq1 && (vis >= 2) && $urandom_range(0, 1);
      if (clr) begin dq1 = 0; dq2 = 0; end
      drive_cycle(clr, v1, v2, rand_pkt(), rand_pkt(), dq1, dq2);
      n_checks++; if (count !== pw_lp'(model_q.size())) begin n_fail++; $display("FAIL rand_count: cycle %0d got %0d expected %0d", i, count, model_q.size()); end
      n_checks++; if (enq_ready !== (model_q.size() <= 6)) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %0b expected %0b", i, enq_ready, model_q.size() <= 6); end
      n_checks++; if ({fe_v1, fe_v2} !== {model_q.size() >= 1, model_q.size() >= 2}) begin n_fail++; $display("FAIL rand_valid: cycle %0d got %b size %0d", i, {fe_v1, fe_v2}, model_q.size()); end
      if (model_q.size() >= 1) begin
        n_checks++; if (fe_q1 !== model_q[0]) begin n_fail++; $display("FAIL rand_q1: cycle %0d got %0h expected %0h", i, fe_q1, model_q[0]); end
      end
      if (model_q.size() >= 2) begin
        n_checks++; if (fe_q2 !== model_q[1]) begin n_fail++; $display("FAIL rand_q2: cycle %0d got %0h expected %0h", i, fe_q2, model_q[1]); end
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_pair();
    test_fill();
    test_wrap();
    test_deq_enq();
    test_clear();
    test_mid_reset();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_fe_dual_queue.md
Name: bp_fe_dual_queue

Overview:
- Dual-issue fetch queue between the FE fetch pipeline and the BE scheduler.
- Accepts up to two fetch packets per cycle from the FE. Presents the oldest two entries to the BE on lanes 1/2 (fe_queue1/fe_queue2).
- The BE retires 0, 1 or 2 entries in order per cycle.
- On a redirect, the FE raises a flush that empties the queue.

Parameters:
- els_p, 8, queue depth in entries; power of 2, minimum 4.
- fe_queue_width_p, 128, width of one FE queue packet in bits.
- ptr_width_lp, $clog2(els_p)+1, pointer width (index plus wrap bit). Localparam.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- clear_i  in  1  flush all entries (FE redirect)
- enq_v1_i  in  1  lane-1 enqueue valid
- enq_v2_i  in  1  lane-2 enqueue valid
- enq1_i  in  fe_queue_width_p  lane-1 packet (older)
- enq2_i  in  fe_queue_width_p  lane-2 packet (younger)
- enq_ready_o  out  1  at least two free entries
- fe_queue1_o  out  fe_queue_width_p  oldest entry
- fe_queue2_o  out  fe_queue_width_p  second-oldest entry
- fe_queue_v1_o  out  1  fe_queue1_o valid
- fe_queue_v2_o  out  1  fe_queue2_o valid
- deq_v1_i  in  1  BE consumes fe_queue1_o
- deq_v2_i  in  1  BE consumes fe_queue2_o
- count_o  out  ptr_width_lp  current occupancy

Behaviour:
- Reset (reset_n_i low, async): rd/wr pointers = 0, count_o = 0, all storage = 0, enq_ready_o = 1, fe_queue_v1_o/v2_o = 0, fe_queue1_o/2_o = 0.
- Storage: els_p-entry circular buffer. Pointers are ptr_width_lp wide. Index = low bits; wrap bit distinguishes full from empty.
- count = wr_ptr - rd_ptr, modulo 2^ptr_width_lp.
- enq_ready_o = (els_p - count >= 2). It depends only on registered state, never on same-cycle inputs.
- Enqueue is legal only when enq_ready_o = 1. Enqueue with enq_ready_o = 0 is a protocol error (assertion); the queue drops the data and leaves state unchanged.
- Enqueue lane compaction:
  - v1 only: write enq1 at wr, wr += 1.
  - v2 only: write enq2 at wr, wr += 1.
  - both: enq1 at wr, enq2 at wr+1, wr += 2.
- Dequeue:
  - fe_queue_v1_o = (count >= 1), fe_queue_v2_o = (count >= 2).
  - Data read combinationally from mem[rd] and mem[rd+1], index wraps modulo els_p.
  - rd += deq_v1_i + deq_v2_i.
  - Legal only if deq_v2_i implies deq_v1_i, and deq_vN_i implies fe_queue_vN_o; violations are asserted.
- Enqueue and dequeue in the same cycle are independent. Full-to-drain and empty-to-fill behave correctly in that cycle. Latency enqueue to visible output: 1 cycle.
- clear_i has priority over everything: next cycle rd = wr = 0 and count = 0. Same-cycle enqueue and dequeue are ignored; storage contents are not cleared.
- Wrap: pointers roll over modulo 2^ptr_width_lp. Lane-2 write at index els_p-1 plus 1 goes to index 0.
- Reset asserted mid-operation discards all contents immediately. Outputs go to reset values asynchronously.

Optional Feature:
- Macro: BP_FE_QUEUE_BYPASS_EN.
- Enabled: when count = 0 and clear_i = 0, enqueued packets are forwarded combinationally to the outputs in the same cycle.
  - fe_queue_v1_o = enq_v1_i | enq_v2_i; fe_queue_v2_o = enq_v1_i & enq_v2_i; data from the compacted enqueue lanes.
  - Bypassed packets consumed by deq_v* in that cycle are not written. wr advances by (enqueued - dequeued).
  - When count = 1, lane 2 may bypass from compacted enqueue lane 1.
- Disabled: outputs depend only on registered state; minimum latency is 1 cycle.

Decomposition:
- Shared package bp_fe_pkg: fe queue packet width constant; lane-count constant (2); assertion message enum.
- Sub-module bp_fe_dual_queue_mem: els_p x fe_queue_width_p storage with 2 write ports and 2 asynchronous read ports, async reset.
- Pointer, count and bypass logic stay in the top module.

Test Plan (els_p = 8):
- Reset, then enq_v1 = enq_v2 = 1 with A, B -> next cycle v1 = v2 = 1, fe_queue1_o = A, fe_queue2_o = B, count_o = 2.
- Enqueue 2 per cycle, no dequeue, for 3 cycles -> count_o = 6, enq_ready_o = 1. One more pair -> count_o = 8, enq_ready_o = 0. Attempted enqueue is dropped, count stays 8.
- Queue holding 7 entries, enq_v2 only with C -> C lands at the correct index. Drain to confirm order; pointer wrap past index 7 preserves FIFO order over 20 mixed cycles.
- count = 1 with entry D, enqueue E and F while deq_v1 = 1 -> next cycle count_o = 2, outputs E, F.
- count = 5, clear_i = 1 with simultaneous enqueue and deq_v1 -> next cycle count_o = 0, v1 = v2 = 0, enq_ready_o = 1.
- With BP_FE_QUEUE_BYPASS_EN: empty queue, enq_v1 = 1 with G and deq_v1 = 1 in the same cycle -> fe_queue1_o = G, fe_queue_v1_o = 1 that cycle; next cycle count_o = 0. Without the macro -> fe_queue_v1_o = 0 that cycle.
